// File: rtl/syn_ctrl_pkg.sv
// syn_ctrl_pkg: sweep FSM states, default geometry and SRAM address composition
package syn_ctrl_pkg;
    localparam int DEF_INPUT_NEURON = 784;
    localparam int DEF_OUTPUT_NEURON = 256;
    localparam int DEF_POST_NEUR_PARALLEL = 4;
    localparam int WORDS = DEF_OUTPUT_NEURON / DEF_POST_NEUR_PARALLEL;
    typedef enum logic [3:0] {
        IDLE, HOST_RD, PRE_FETCH, PRE_CHECK, READ, WAIT, WRITE, NEXT_ROW, DONE_S
    } state_t;
    function automatic logic [31:0] compose_addr(input logic [31:0] row, input logic [31:0] word, input logic [31:0] words = WORDS);
        return row * words + word;
    endfunction
endpackage

// File: rtl/syn_addr_gen.sv
// syn_addr_gen: row/word counters with look-ahead SRAM, pre-row and post-neuron addresses
module syn_addr_gen
    import syn_ctrl_pkg::*;
#(
    parameter int INPUT_NEURON = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL = DEF_POST_NEUR_PARALLEL,
    parameter int PRE_NEUR_ADDR_WIDTH = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            clr,
    input  logic                            inc_word,
    input  logic                            inc_row,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  row_n,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_n,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] post_n,
    output logic                            last_word,
    output logic                            last_row
);
    localparam int NWORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] row;
    logic [POST_NEUR_ADDR_WIDTH-1:0] word, word_n;
    // next counter values, so the top registers addresses in step with its next state
    always_comb begin
        row_n = clr ? '0 : inc_row ? row + 1'b1 : row;
        word_n = (clr || inc_row) ? '0 : inc_word ? word + 1'b1 : word;
    end
    // counters restart at row 0, word 0 on reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            row <= '0;
            word <= '0;
        end else begin
            row <= row_n;
            word <= word_n;
        end
    end
    assign addr_n = SYN_ARRAY_ADDR_WIDTH'(compose_addr(32'(row_n), 32'(word_n), NWORDS));
    assign post_n = POST_NEUR_ADDR_WIDTH'(32'(word_n) * POST_NEUR_PARALLEL);
    assign last_word = word == POST_NEUR_ADDR_WIDTH'(NWORDS - 1);
    assign last_row = row == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
endmodule

// File: rtl/syn_update_scheduler.sv
// syn_update_scheduler: FF-STDP weight-update sweep sequencer with idle-time host SRAM reads
module syn_update_scheduler
    import syn_ctrl_pkg::*;
#(
    parameter int INPUT_NEURON = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL = DEF_POST_NEUR_PARALLEL,
    parameter int PRE_NEUR_ADDR_WIDTH = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16,
    parameter int PRE_NEUR_DATA_WIDTH = 8,
    parameter int UPD_LAT = 1,
    parameter int SKIP_ZERO_PRE = 1
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            START,
    input  logic                            IS_TRAIN,
    input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT,
    input  logic                            HOST_REQ,
    input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] HOST_ADDR,
    output logic                            HOST_ACK,
    output logic                            HOST_RVALID,
    output logic                            CTRL_SYNARRAY_CS,
    output logic                            CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
    output logic                            CTRL_PRE_NEUR_RD,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEUR_ADDR,
    output logic                            CTRL_POST_NEUR_RD,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic                            BUSY,
    output logic                            DONE
);
    state_t state, state_n;
    logic [1:0] wait_cnt;
    logic clr, inc_word, inc_row, last_word, last_row;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] row_n;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_n;
    logic [POST_NEUR_ADDR_WIDTH-1:0] post_n;

    syn_addr_gen #(
        .INPUT_NEURON(INPUT_NEURON),
        .OUTPUT_NEURON(OUTPUT_NEURON),
        .POST_NEUR_PARALLEL(POST_NEUR_PARALLEL),
        .PRE_NEUR_ADDR_WIDTH(PRE_NEUR_ADDR_WIDTH),
        .POST_NEUR_ADDR_WIDTH(POST_NEUR_ADDR_WIDTH),
        .SYN_ARRAY_ADDR_WIDTH(SYN_ARRAY_ADDR_WIDTH)
    ) u_addr (
        .CLK(CLK),
        .RST_N(RST_N),
        .clr(clr),
        .inc_word(inc_word),
        .inc_row(inc_row),
        .row_n(row_n),
        .addr_n(addr_n),
        .post_n(post_n),
        .last_word(last_word),
        .last_row(last_row)
    );

    // next-state and counter steering; a start request takes priority over a pending host read
    always_comb begin
        state_n = state;
        clr = 1'b0;
        inc_word = 1'b0;
        inc_row = 1'b0;
        case (state)
            IDLE: begin
                clr = START && IS_TRAIN;
                state_n = (START && IS_TRAIN) ? PRE_FETCH : HOST_REQ ? HOST_RD : IDLE;
            end
            HOST_RD:   state_n = IDLE;
            PRE_FETCH: state_n = PRE_CHECK;
            PRE_CHECK: state_n = (SKIP_ZERO_PRE != 0 && PRE_NEUR_S_CNT == '0) ? NEXT_ROW : READ;
            READ:      state_n = WAIT;
            WAIT:      state_n = (wait_cnt == 2'(UPD_LAT)) ? WRITE : WAIT;
            WRITE: begin
                inc_word = !last_word;
                state_n = last_word ? NEXT_ROW : READ;
            end
            NEXT_ROW: begin
                inc_row = !last_row;
                state_n = last_row ? DONE_S : PRE_FETCH;
            end
            DONE_S:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // state, wait counter and outputs registered from the next state so they line up with it
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            wait_cnt <= '0;
            HOST_ACK <= 1'b0;
            HOST_RVALID <= 1'b0;
            CTRL_SYNARRAY_CS <= 1'b0;
            CTRL_SYNARRAY_WE <= 1'b0;
            CTRL_SYNARRAY_ADDR <= '0;
            CTRL_PRE_NEUR_RD <= 1'b0;
            CTRL_PRE_NEUR_ADDR <= '0;
            CTRL_POST_NEUR_RD <= 1'b0;
            CTRL_POST_NEURON_ADDRESS <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            state <= state_n;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            HOST_ACK <= state_n == HOST_RD;
            HOST_RVALID <= state == HOST_RD;
            CTRL_SYNARRAY_CS <= state_n inside {HOST_RD, READ, WRITE};
            CTRL_SYNARRAY_WE <= state_n == WRITE;
            CTRL_SYNARRAY_ADDR <= (state_n == HOST_RD) ? HOST_ADDR : addr_n;
            CTRL_PRE_NEUR_RD <= state_n == PRE_FETCH;
            CTRL_PRE_NEUR_ADDR <= row_n;
            CTRL_POST_NEUR_RD <= state_n == READ;
            CTRL_POST_NEURON_ADDRESS <= post_n;
            BUSY <= !(state_n inside {IDLE, HOST_RD});
            DONE <= state_n == DONE_S;
        end
    end
endmodule

// File: tb/tb_syn_update_scheduler.sv
// tb_syn_update_scheduler: directed checks of sweep order, skipping, host reads, reset abort and update latency
module tb_syn_update_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start3, is_train, host_req;
    logic [15:0] host_addr;
    logic [7:0] cnt [0:1];
    logic [7:0] pre_q, pre_q3;

    logic ack, rvalid, cs, we, pre_rd, post_rd, busy, done;
    logic [15:0] addr;
    logic [9:0] pre_addr, post_addr;
    logic ack3, rvalid3, cs3, we3, pre_rd3, post_rd3, busy3, done3;
    logic [15:0] addr3;
    logic [9:0] pre_addr3, post_addr3;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] rd_q[$], wr_q[$];
    logic [9:0] pst_q[$];
    int rd_t[$], wr_t[$];
    int done_k, ack_k, rv_k, busy_cnt, ack_busy;

    syn_update_scheduler #(.INPUT_NEURON(2), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(2), .UPD_LAT(1)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .IS_TRAIN(is_train), .PRE_NEUR_S_CNT(pre_q),
        .HOST_REQ(host_req), .HOST_ADDR(host_addr), .HOST_ACK(ack), .HOST_RVALID(rvalid),
        .CTRL_SYNARRAY_CS(cs), .CTRL_SYNARRAY_WE(we), .CTRL_SYNARRAY_ADDR(addr),
        .CTRL_PRE_NEUR_RD(pre_rd), .CTRL_PRE_NEUR_ADDR(pre_addr), .CTRL_POST_NEUR_RD(post_rd),
        .CTRL_POST_NEURON_ADDRESS(post_addr), .BUSY(busy), .DONE(done)
    );

    syn_update_scheduler #(.INPUT_NEURON(2), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(2), .UPD_LAT(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .START(start3), .IS_TRAIN(is_train), .PRE_NEUR_S_CNT(pre_q3),
        .HOST_REQ(1'b0), .HOST_ADDR(host_addr), .HOST_ACK(ack3), .HOST_RVALID(rvalid3),
        .CTRL_SYNARRAY_CS(cs3), .CTRL_SYNARRAY_WE(we3), .CTRL_SYNARRAY_ADDR(addr3),
        .CTRL_PRE_NEUR_RD(pre_rd3), .CTRL_PRE_NEUR_ADDR(pre_addr3), .CTRL_POST_NEUR_RD(post_rd3),
        .CTRL_POST_NEURON_ADDRESS(post_addr3), .BUSY(busy3), .DONE(done3)
    );

    // pre-neuron count memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (pre_rd) pre_q <= cnt[pre_addr[0]];
        if (pre_rd3) pre_q3 <= cnt[pre_addr3[0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pulses START in the cycle numbered 0 and logs SRAM traffic per cycle k until 3 cycles past DONE
    task automatic run_sweep(input bit sel, input int budget, input int host_at);
        logic b, c, w, d, a, r;
        logic [15:0] ad;
        logic [9:0] pa;
        rd_q.delete(); rd_t.delete(); wr_q.delete(); wr_t.delete(); pst_q.delete();
        done_k = -1; ack_k = -1; rv_k = -1; busy_cnt = 0; ack_busy = 0;
        @(negedge clk);
        if (sel) start3 = 1'b1; else start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = 1'b0;
            start3 = 1'b0;
            if (k == host_at) begin
                host_req = 1'b1;
                is_train = 1'b0;
            end
            b = sel ? busy3 : busy;
            c = sel ? cs3 : cs;
            w = sel ? we3 : we;
            d = sel ? done3 : done;
            a = sel ? ack3 : ack;
            r = sel ? rvalid3 : rvalid;
            ad = sel ? addr3 : addr;
            pa = sel ? post_addr3 : post_addr;
            if (b) busy_cnt++;
            if (b && c && !w) begin rd_q.push_back(ad); rd_t.push_back(k); pst_q.push_back(pa); end
            if (b && c && w) begin wr_q.push_back(ad); wr_t.push_back(k); end
            if (b && a) ack_busy++;
            if (d && done_k < 0) done_k = k;
            if (a && ack_k < 0) begin
                ack_k = k;
                host_req = 1'b0;
                is_train = 1'b1;
            end
            if (r && rv_k < 0) rv_k = k;
            if (done_k > 0 && k >= done_k + 3) break;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; is_train = 1'b1; host_req = 1'b0; host_addr = '0;
        cnt[0] = 8'd3; cnt[1] = 8'd5;
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({ack, rvalid, cs, we, pre_rd, post_rd, busy, done}), 0);
        chk("reset_addr", 32'(addr), 0);
        chk("reset_pre_addr", 32'(pre_addr), 0);
        chk("reset_post_addr", 32'(post_addr), 0);
        rst_n = 1'b1;

        run_sweep(0, 80, 0);
        chk("full_done_cycle", done_k, 39);
        chk("full_busy_cycles", busy_cnt, 39);
        chk("full_reads", rd_q.size(), 8);
        chk("full_writes", wr_q.size(), 8);
        for (int i = 0; i < rd_q.size(); i++) begin
            chk("full_rd_addr", 32'(rd_q[i]), i);
            chk("full_post_addr", 32'(pst_q[i]), (i % 4) * 2);
        end
        for (int i = 0; i < wr_q.size(); i++) chk("full_wr_addr", 32'(wr_q[i]), i);
        chk("full_first_read", rd_t[0], 3);
        chk("full_first_write", wr_t[0], 6);
        chk("full_last_write", wr_t[wr_t.size() - 1], 37);
        chk("full_busy_after", 32'(busy), 0);
        chk("full_done_after", 32'(done), 0);

        cnt[0] = 8'd0;
        run_sweep(0, 80, 0);
        chk("skip_done_cycle", done_k, 23);
        chk("skip_reads", rd_q.size(), 4);
        chk("skip_writes", wr_q.size(), 4);
        chk("skip_first_rd_addr", 32'(rd_q[0]), 4);
        chk("skip_first_read", rd_t[0], 6);
        chk("skip_last_wr_addr", 32'(wr_q[wr_q.size() - 1]), 7);
        cnt[0] = 8'd3;

        @(negedge clk);
        host_addr = 16'h0005;
        host_req = 1'b1;
        @(negedge clk);
        chk("host_ack", 32'(ack), 1);
        chk("host_cs", 32'(cs), 1);
        chk("host_we", 32'(we), 0);
        chk("host_addr", 32'(addr), 5);
        chk("host_rvalid_early", 32'(rvalid), 0);
        host_req = 1'b0;
        @(negedge clk);
        chk("host_rvalid", 32'(rvalid), 1);
        chk("host_ack_drop", 32'(ack), 0);
        chk("host_cs_drop", 32'(cs), 0);

        run_sweep(0, 80, 10);
        chk("mid_done_cycle", done_k, 39);
        chk("mid_writes", wr_q.size(), 8);
        chk("mid_ack_busy", ack_busy, 0);
        chk("mid_ack_cycle", ack_k, 41);
        chk("mid_rvalid_cycle", rv_k, 42);

        is_train = 1'b0;
        run_sweep(0, 6, 0);
        chk("notrain_busy", busy_cnt, 0);
        chk("notrain_done", done_k, -1);
        chk("notrain_cs", rd_q.size() + wr_q.size(), 0);
        is_train = 1'b1;

        @(negedge clk);
        start = 1'b1;
        repeat (31) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_wait_cs", 32'(cs), 0);
        chk("abort_wait_addr", 32'(addr), 6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_flags", 32'({ack, rvalid, cs, we, pre_rd, post_rd, busy, done}), 0);
        chk("abort_addr", 32'(addr), 0);
        chk("abort_pre_addr", 32'(pre_addr), 0);
        chk("abort_post_addr", 32'(post_addr), 0);
        rst_n = 1'b1;
        run_sweep(0, 80, 0);
        chk("restart_first_addr", 32'(rd_q[0]), 0);
        chk("restart_first_read", rd_t[0], 3);
        chk("restart_done_cycle", done_k, 39);

        run_sweep(1, 100, 0);
        chk("lat3_done_cycle", done_k, 55);
        chk("lat3_first_read", rd_t[0], 3);
        chk("lat3_first_write", wr_t[0], 8);
        chk("lat3_spacing", wr_t[1] - rd_t[1], 5);
        chk("lat3_same_addr", 32'(wr_q[2]), 32'(rd_q[2]));
        chk("lat3_writes", wr_q.size(), 8);
        for (int i = 0; i < wr_q.size(); i++) chk("lat3_wr_addr", 32'(wr_q[i]), i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
